// File: rtl/alu_mdu.sv
// Registered EX-stage ALU with iterative unsigned multiply/divide.
// Single-cycle ops complete in one edge; MULTU/DIVU take N iterations under a busy/done handshake.
module alu_mdu #(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   func,
  input  logic [N-1:0] inp1,
  input  logic [N-1:0] inp2,
  output logic [N-1:0] out,
  output logic [N-1:0] hi,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t         state;
  logic [SW-1:0]  count;
  logic [N-1:0]   opb;
  logic [2*N-1:0] work;

  logic [N-1:0]   alu_res;
  logic           alu_write;
  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_next;
  logic [N:0]     div_shift;
  logic [N:0]     div_diff;
  logic [2*N-1:0] div_next;
  logic           last_iter;

  always_comb begin
    alu_res   = '0;
    alu_write = 1'b1;
    case (func)
      4'b0000: alu_res = inp1 & inp2;
      4'b0001: alu_res = inp1 | inp2;
      4'b0010: alu_res = inp1 + inp2;
      4'b0110: alu_res = inp1 - inp2;
      4'b0111: alu_res = {{(N-1){1'b0}}, $signed(inp1) < $signed(inp2)};
      4'b1000: alu_res = {{(N-1){1'b0}}, inp1 < inp2};
      4'b1001: alu_res = inp1 ^ inp2;
      4'b1010: alu_res = ~(inp1 | inp2);
      4'b1011: alu_res = inp2 << inp1[SW-1:0];
      4'b1100: alu_res = inp2 >> inp1[SW-1:0];
      4'b1101: alu_res = $signed(inp2) >>> inp1[SW-1:0];
      default: alu_write = 1'b0;
    endcase
  end

  // work holds {accumulator, multiplier} for MULTU and {remainder, dividend/quotient} for DIVU.
  always_comb begin
    mul_sum   = {1'b0, work[2*N-1:N]} + (work[0] ? {1'b0, opb} : {(N+1){1'b0}});
    mul_next  = {mul_sum, work[N-1:1]};
    div_shift = {work[2*N-1:N], work[N-1]};
    div_diff  = div_shift - {1'b0, opb};
    div_next  = div_diff[N] ? {div_shift[N-1:0], work[N-2:0], 1'b0}
                            : {div_diff[N-1:0],  work[N-2:0], 1'b1};
    last_iter = (count == SW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      opb   <= '0;
      work  <= '0;
      out   <= '0;
      hi    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (func == 4'b1110) begin
              state <= MUL;
              busy  <= 1'b1;
              count <= '0;
              opb   <= inp1;
              work  <= {{N{1'b0}}, inp2};
            end else if (func == 4'b1111 && inp2 != '0) begin
              state <= DIV;
              busy  <= 1'b1;
              count <= '0;
              opb   <= inp2;
              work  <= {{N{1'b0}}, inp1};
            end else begin
              done <= 1'b1;
              if (func == 4'b1111) begin
                out <= '1;
                hi  <= inp1;
              end else if (alu_write) begin
                out <= alu_res;
              end
            end
          end
        end
        MUL: begin
          work  <= mul_next;
          count <= count + SW'(1);
          if (last_iter) begin
            out   <= mul_next[N-1:0];
            hi    <= mul_next[2*N-1:N];
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            count <= '0;
          end
        end
        DIV: begin
          work  <= div_next;
          count <= count + SW'(1);
          if (last_iter) begin
            out   <= div_next[N-1:0];
            hi    <= div_next[2*N-1:N];
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu (N=32) with hand-computed expectations.
module tb_alu_mdu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  func;
  logic [31:0] inp1;
  logic [31:0] inp2;
  logic [31:0] out;
  logic [31:0] hi;
  logic        busy;
  logic        done;

  int checks;
  int failures;
  int edges;
  int busy_cycles;
  int done_seen;

  alu_mdu #(.N(32)) dut (
    .clk(clk), .rst(rst), .start(start), .func(func),
    .inp1(inp1), .inp2(inp2), .out(out), .hi(hi), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Presents one op for exactly one rising edge, returning 1ns after that edge.
  task automatic applyStimulus(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    func  = f;
    inp1  = a;
    inp2  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(output int e, output int bc);
    e  = 0;
    bc = 0;
    while (!done && e < 100) begin
      if (busy) bc++;
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic singleOp(input string tag, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    applyStimulus(f, a, b);
    checkOutput({tag, "_done"}, {31'b0, done}, 32'd1);
    checkOutput({tag, "_out"}, out, exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst   = 1'b0;
    start = 1'b0;
    func  = 4'b0011;
    inp1  = '0;
    inp2  = '0;
    #12;
    checkOutput("rst_out",  out, 32'd0);
    checkOutput("rst_hi",   hi, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    singleOp("add", 4'b0010, 32'd7, 32'hFFFF_FFFD, 32'd4);
    checkOutput("add_busy", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("add_pulse", {31'b0, done}, 32'd0);
    singleOp("sub",  4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE);
    singleOp("slt",  4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1);
    singleOp("sltu", 4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd0);
    singleOp("and",  4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    singleOp("or",   4'b0001, 32'hF000_0001, 32'h0000_0100, 32'hF000_0101);
    singleOp("xor",  4'b1001, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
    singleOp("nor",  4'b1010, 32'hF000_0000, 32'h0000_000F, 32'h0FFF_FFF0);
    singleOp("sll",  4'b1011, 32'd4, 32'd1, 32'h10);
    singleOp("sra",  4'b1101, 32'd31, 32'h8000_0000, 32'hFFFF_FFFF);
    singleOp("srl",  4'b1100, 32'd31, 32'h8000_0000, 32'd1);
    singleOp("nop",  4'b0011, 32'd99, 32'd99, 32'd1);
    singleOp("nop4", 4'b0100, 32'd98, 32'd98, 32'd1);
    checkOutput("single_hi", hi, 32'd0);

    // Asynchronous reset in the middle of a multiply.
    singleOp("add2", 4'b0010, 32'd7, 32'hFFFF_FFFD, 32'd4);
    applyStimulus(4'b1110, 32'd9, 32'd9);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("midrst_out",  out, 32'd0);
    checkOutput("midrst_hi",   hi, 32'd0);
    checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
    checkOutput("midrst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Multiply with operands scrambled while busy.
    applyStimulus(4'b1110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("mul_busy0", {31'b0, busy}, 32'd1);
    checkOutput("mul_done0", {31'b0, done}, 32'd0);
    func = 4'b1111;
    inp1 = 32'd3;
    inp2 = 32'd0;
    waitDone(edges, busy_cycles);
    checkOutput("mul_edges", edges, 32'd32);
    checkOutput("mul_busycyc", busy_cycles, 32'd32);
    checkOutput("mul_hi", hi, 32'hFFFF_FFFE);
    checkOutput("mul_out", out, 32'h0000_0001);
    checkOutput("mul_busyend", {31'b0, busy}, 32'd0);

    applyStimulus(4'b1111, 32'd100, 32'd7);
    waitDone(edges, busy_cycles);
    checkOutput("div_busycyc", busy_cycles, 32'd32);
    checkOutput("div_out", out, 32'd14);
    checkOutput("div_hi", hi, 32'd2);

    applyStimulus(4'b1111, 32'd5, 32'd0);
    checkOutput("div0_done", {31'b0, done}, 32'd1);
    checkOutput("div0_busy", {31'b0, busy}, 32'd0);
    checkOutput("div0_out", out, 32'hFFFF_FFFF);
    checkOutput("div0_hi", hi, 32'd5);

    // A start pulse during a multiply must be dropped, not queued.
    applyStimulus(4'b1110, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    applyStimulus(4'b0010, 32'd1, 32'd1);
    waitDone(edges, busy_cycles);
    checkOutput("ign_edges", edges, 32'd27);
    checkOutput("ign_out", out, 32'd15);
    checkOutput("ign_hi", hi, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("ign_noq_done", {31'b0, done}, 32'd0);
    checkOutput("ign_noq_out", out, 32'd15);

    // start held across a completion launches the next op in the done cycle.
    @(negedge clk);
    start = 1'b1;
    func  = 4'b1110;
    inp1  = 32'd2;
    inp2  = 32'd3;
    @(posedge clk);
    #1;
    func = 4'b0010;
    inp1 = 32'd10;
    inp2 = 32'd20;
    waitDone(edges, busy_cycles);
    checkOutput("held_edges", edges, 32'd32);
    checkOutput("held_mul_out", out, 32'd6);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("held_next_done", {31'b0, done}, 32'd1);
    checkOutput("held_next_out", out, 32'd30);

    // Reset at iteration 10 of a divide discards the partial result.
    applyStimulus(4'b1111, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("divrst_busy", {31'b0, busy}, 32'd0);
    checkOutput("divrst_out", out, 32'd0);
    checkOutput("divrst_hi", hi, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    checkOutput("divrst_nodone", done_seen, 32'd0);
    applyStimulus(4'b1111, 32'd100, 32'd7);
    waitDone(edges, busy_cycles);
    checkOutput("divrst_again_out", out, 32'd14);
    checkOutput("divrst_again_hi", hi, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
